// File: rtl/mux8_scanner.sv
// mux8_scanner: steps an external 8:1 mux through channels 0..7, waits SETTLE cycles per channel, samples z0.
// Optional MUX8_SCANNER_AUTO_EN: scans repeat back-to-back forever after the first start.
module mux8_scanner #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       z0,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic [7:0] data,
  output logic       valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

  state_t      state_q;
  logic [2:0]  ch_q;
  logic [7:0]  cnt_q;
  logic [6:0]  shadow_q;
  logic        busy_q;
  logic        valid_q;
  logic [7:0]  data_q;

  // Selects come straight from the channel register, so they only move when ch_q does.
  assign {s2, s1, s0} = ch_q;
  assign busy  = busy_q;
  assign valid = valid_q;
  assign data  = data_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      ch_q     <= 3'd0;
      cnt_q    <= 8'd0;
      shadow_q <= 7'd0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            state_q <= ST_SETTLE;
            ch_q    <= 3'd0;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == SettleLast) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // Channel 7 goes straight into data, so the shadow only holds 0..6.
          if (ch_q != 3'd7) begin
            shadow_q[ch_q] <= z0;
            ch_q           <= ch_q + 3'd1;
            cnt_q          <= 8'd0;
            state_q        <= ST_SETTLE;
          end else begin
            data_q  <= {z0, shadow_q};
            valid_q <= 1'b1;
            ch_q    <= 3'd0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
`ifdef MUX8_SCANNER_AUTO_EN
          state_q <= ST_SETTLE;
          ch_q    <= 3'd0;
          cnt_q   <= 8'd0;
          busy_q  <= 1'b1;
`else
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
`endif
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
